// File: rtl/prio_encoder_hs.sv
// Registered priority encoder with valid/ready on both sides.
// One output register, pass-through backpressure, saturating multi-hot error counter.
module prio_encoder_hs #(
    parameter int IN_W      = 8,
    parameter int OUT_W     = $clog2(IN_W),
    parameter bit MSB_FIRST = 1'b1,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [IN_W-1:0]  in_vec,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_idx,
    output logic             out_zero,
    output logic             out_multi,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             err_clr,
    output logic [ERR_W-1:0] err_cnt
);

    logic [OUT_W-1:0] out_idx_q, out_idx_d;
    logic             out_zero_q, out_zero_d;
    logic             out_multi_q, out_multi_d;
    logic             out_valid_q, out_valid_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [OUT_W-1:0] enc_idx;
    logic             enc_zero;
    logic             enc_multi;
    logic             accept;
    logic             consume;

    // Scan in reverse priority order so the last hit seen is the winner.
    always_comb begin
        int pos;
        pos       = 0;
        enc_idx   = '0;
        enc_zero  = 1'b1;
        enc_multi = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            pos = MSB_FIRST ? i : (IN_W - 1 - i);
            if (in_vec[pos]) begin
                if (!enc_zero) begin
                    enc_multi = 1'b1;
                end
                enc_zero = 1'b0;
                enc_idx  = OUT_W'(pos);
            end
        end
    end

    // Gated by rst_n so the block never advertises readiness while held in reset.
    assign in_ready = rst_n & enable & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid_q & out_ready;

    always_comb begin
        out_idx_d   = out_idx_q;
        out_zero_d  = out_zero_q;
        out_multi_d = out_multi_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_idx_d   = enc_idx;
            out_zero_d  = enc_zero;
            out_multi_d = enc_multi;
            out_valid_d = 1'b1;
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (accept && enc_multi && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx_q   <= '0;
            out_zero_q  <= 1'b0;
            out_multi_q <= 1'b0;
            out_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            out_idx_q   <= out_idx_d;
            out_zero_q  <= out_zero_d;
            out_multi_q <= out_multi_d;
            out_valid_q <= out_valid_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_idx   = out_idx_q;
    assign out_zero  = out_zero_q;
    assign out_multi = out_multi_q;
    assign out_valid = out_valid_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Bench for prio_encoder_hs: three configurations share one stimulus stream,
// checked every cycle against a behavioural model plus hand-computed literals.
module tb_prio_encoder_hs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [11:0] vec;
    logic        in_valid;
    logic        out_ready;
    logic        err_clr;

    logic       rdy_a, zero_a, multi_a, valid_a;
    logic [2:0] idx_a;
    logic [7:0] err_a;
    logic       rdy_b, zero_b, multi_b, valid_b;
    logic [2:0] idx_b;
    logic [1:0] err_b;
    logic       rdy_c, zero_c, multi_c, valid_c;
    logic [3:0] idx_c;
    logic [7:0] err_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prio_encoder_hs #(.IN_W(8), .MSB_FIRST(1'b1), .ERR_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_vec(vec[7:0]),
        .in_valid(in_valid), .in_ready(rdy_a), .out_idx(idx_a), .out_zero(zero_a),
        .out_multi(multi_a), .out_valid(valid_a), .out_ready(out_ready),
        .err_clr(err_clr), .err_cnt(err_a)
    );

    prio_encoder_hs #(.IN_W(8), .MSB_FIRST(1'b0), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_vec(vec[7:0]),
        .in_valid(in_valid), .in_ready(rdy_b), .out_idx(idx_b), .out_zero(zero_b),
        .out_multi(multi_b), .out_valid(valid_b), .out_ready(out_ready),
        .err_clr(err_clr), .err_cnt(err_b)
    );

    prio_encoder_hs #(.IN_W(12), .MSB_FIRST(1'b1), .ERR_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_vec(vec),
        .in_valid(in_valid), .in_ready(rdy_c), .out_idx(idx_c), .out_zero(zero_c),
        .out_multi(multi_c), .out_valid(valid_c), .out_ready(out_ready),
        .err_clr(err_clr), .err_cnt(err_c)
    );

    // Per-instance configuration: width, priority direction, counter ceiling
    function automatic int cfg_w(int k);
        return (k == 2) ? 12 : 8;
    endfunction
    function automatic bit cfg_msb(int k);
        return (k != 1);
    endfunction
    function automatic int cfg_max(int k);
        return (k == 1) ? 3 : 255;
    endfunction

    function automatic logic [11:0] vec_for(int k, logic [11:0] v);
        logic [12:0] m;
        m = (13'd1 << cfg_w(k)) - 13'd1;
        return v & m[11:0];
    endfunction

    function automatic int winner(logic [11:0] v, int w, bit msb);
        if (msb) begin
            for (int i = w - 1; i >= 0; i--) if (v[i]) return i;
        end else begin
            for (int i = 0; i < w; i++) if (v[i]) return i;
        end
        return 0;
    endfunction

    int m_idx[3];
    int m_err[3];
    bit m_zero[3];
    bit m_multi[3];
    bit m_valid[3];

    function automatic bit m_rdy(int k);
        return rst_n && enable && (!m_valid[k] || out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_idx[k]   <= 0;
                m_err[k]   <= 0;
                m_zero[k]  <= 1'b0;
                m_multi[k] <= 1'b0;
                m_valid[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (in_valid && m_rdy(k)) begin
                    m_idx[k]   <= winner(vec_for(k, vec), cfg_w(k), cfg_msb(k));
                    m_zero[k]  <= ($countones(vec_for(k, vec)) == 0);
                    m_multi[k] <= ($countones(vec_for(k, vec)) >= 2);
                    m_valid[k] <= 1'b1;
                end else if (m_valid[k] && out_ready) begin
                    m_valid[k] <= 1'b0;
                end
                if (err_clr)
                    m_err[k] <= 0;
                else if (in_valid && m_rdy(k) && $countones(vec_for(k, vec)) >= 2
                         && m_err[k] < cfg_max(k))
                    m_err[k] <= m_err[k] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string n, input int k, input logic [31:0] idx, input logic zero,
                       input logic multi, input logic valid, input logic [31:0] err,
                       input logic rdy);
        check({n, ".out_valid"}, 32'(valid), 32'(m_valid[k]));
        check({n, ".out_idx"}, idx, 32'(m_idx[k]));
        check({n, ".out_zero"}, 32'(zero), 32'(m_zero[k]));
        check({n, ".out_multi"}, 32'(multi), 32'(m_multi[k]));
        check({n, ".err_cnt"}, err, 32'(m_err[k]));
        check({n, ".in_ready"}, 32'(rdy), 32'(m_rdy(k)));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp("a", 0, 32'(idx_a), zero_a, multi_a, valid_a, 32'(err_a), rdy_a);
            cmp("b", 1, 32'(idx_b), zero_b, multi_b, valid_b, 32'(err_b), rdy_b);
            cmp("c", 2, 32'(idx_c), zero_c, multi_c, valid_c, 32'(err_c), rdy_c);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int exp_b_err[5] = '{1, 2, 3, 3, 3};
    logic [11:0] mh_vec[5] = '{12'h003, 12'h006, 12'h00C, 12'h018, 12'h030};

    initial begin
        rst_n = 1'b0; enable = 1'b1; vec = '0; in_valid = 1'b0;
        out_ready = 1'b1; err_clr = 1'b0;
        repeat (2) cyc();
        check("reset.in_ready", 32'(rdy_a), 32'd0);
        check("reset.out_valid", 32'(valid_a), 32'd0);
        check("reset.err_cnt", 32'(err_a), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Back-to-back one-hot vectors
        in_valid = 1'b1;
        vec = 12'h001; cyc(); check("t1.idx0", 32'(idx_a), 32'd0);
        vec = 12'h002; cyc(); check("t1.idx1", 32'(idx_a), 32'd1);
        vec = 12'h010; cyc(); check("t1.idx4", 32'(idx_a), 32'd4);
        check("t1.lsb_idx4", 32'(idx_b), 32'd4);
        vec = 12'h080; cyc(); check("t1.idx7", 32'(idx_a), 32'd7);
        check("t1.multi", 32'(multi_a), 32'd0);
        check("t1.err", 32'(err_a), 32'd0);

        // Zero vector and multi-hot vector
        vec = 12'h000; cyc();
        check("t2.zero", 32'(zero_a), 32'd1);
        check("t2.zero_valid", 32'(valid_a), 32'd1);
        vec = 12'h022; cyc();
        check("t2.idx5", 32'(idx_a), 32'd5);
        check("t2.multi", 32'(multi_a), 32'd1);
        check("t2.err1", 32'(err_a), 32'd1);
        check("t2.lsb_idx1", 32'(idx_b), 32'd1);

        // Backpressure: held result stays put, pending vector waits
        vec = 12'h004; cyc();
        check("t3.idx2", 32'(idx_a), 32'd2);
        out_ready = 1'b0; vec = 12'h040;
        #1 check("t3.rdy_low", 32'(rdy_a), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t3.hold_idx", 32'(idx_a), 32'd2);
            check("t3.hold_rdy", 32'(rdy_a), 32'd0);
        end
        out_ready = 1'b1;
        #1 check("t3.rdy_high", 32'(rdy_a), 32'd1);
        cyc();
        check("t3.idx6", 32'(idx_a), 32'd6);

        // Enable low: held result consumable, nothing new accepted
        enable = 1'b0; out_ready = 1'b0; vec = 12'h008;
        #1 check("t4.rdy", 32'(rdy_a), 32'd0);
        cyc();
        check("t4.held_valid", 32'(valid_a), 32'd1);
        check("t4.held_idx", 32'(idx_a), 32'd6);
        out_ready = 1'b1;
        cyc();
        check("t4.consumed", 32'(valid_a), 32'd0);
        check("t4.idx_kept", 32'(idx_a), 32'd6);
        cyc();
        check("t4.no_accept", 32'(valid_a), 32'd0);
        enable = 1'b1;
        cyc();
        check("t4.idx3", 32'(idx_a), 32'd3);

        // Saturating counter on the 2-bit instance, clear wins over increment
        in_valid = 1'b0; err_clr = 1'b1; cyc();
        check("t5.pre_clear", 32'(err_b), 32'd0);
        err_clr = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vec = mh_vec[i];
            cyc();
            check("t5.err_b", 32'(err_b), 32'(exp_b_err[i]));
        end
        check("t5.err_a5", 32'(err_a), 32'd5);
        vec = 12'h060; err_clr = 1'b1; cyc();
        check("t5.clr_b", 32'(err_b), 32'd0);
        check("t5.clr_a", 32'(err_a), 32'd0);
        check("t5.idx6", 32'(idx_a), 32'd6);
        err_clr = 1'b0;

        // 12-bit instance, then asynchronous reset while a result is held
        vec = 12'h800; cyc();
        check("t6.idx11", 32'(idx_c), 32'd11);
        check("t6.a_zero", 32'(zero_a), 32'd1);
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t6.rst_valid_c", 32'(valid_c), 32'd0);
        check("t6.rst_valid_a", 32'(valid_a), 32'd0);
        check("t6.rst_idx_c", 32'(idx_c), 32'd0);
        check("t6.rst_rdy", 32'(rdy_c), 32'd0);
        cyc();
        rst_n = 1'b1; out_ready = 1'b1; vec = 12'h800;
        cyc();
        check("t6.cold_idx11", 32'(idx_c), 32'd11);
        check("t6.cold_valid", 32'(valid_c), 32'd1);
        vec = 12'hA00; cyc();
        check("t6.multi_c", 32'(multi_c), 32'd1);
        check("t6.err_c", 32'(err_c), 32'd1);
        in_valid = 1'b0;
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
